lc_token_stream: RTL

Parametrised lifecycle-token store: holds NUM_TOKENS constant tokens of TOKEN_WIDTH bits and returns a requested token as a serialised stream of BUS_WIDTH-bit beats over a valid/ready channel. Sits between the lifecycle controller and narrower consumers (hash/compare datapaths, bus bridges), replacing single-cycle full-width token reads. Supports backpressure, out-of-range/locked error responses, and a sticky per-token read lock.

---
 rtl/lc_token_stream.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/lc_token_stream.sv
// rtl/lc_token_stream.sv - lifecycle token store streamed as BUS_WIDTH beats with sticky read locks
module lc_token_stream #(
    parameter int TOKEN_WIDTH = 256,
    parameter int NUM_TOKENS  = 6,
    parameter int BUS_WIDTH   = 64,
    parameter logic [NUM_TOKENS*TOKEN_WIDTH-1:0] TOKEN_INIT = '0,
    localparam int ADDR_W = (NUM_TOKENS > 1) ? $clog2(NUM_TOKENS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  lock_valid,
    input  logic [NUM_TOKENS-1:0] lock_mask,
    output logic [NUM_TOKENS-1:0] locked,
    output logic [BUS_WIDTH-1:0]  rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  rd_err
);

    localparam int BEATS   = TOKEN_WIDTH / BUS_WIDTH;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TOTAL_W = NUM_TOKENS * TOKEN_WIDTH;
    localparam int IDX_W   = (TOTAL_W > 1) ? $clog2(TOTAL_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        ERR    = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [NUM_TOKENS-1:0]   locked_q, locked_d;
    logic [BUS_WIDTH-1:0]    data_q, data_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic                    valid_q, valid_d;

    logic [NUM_TOKENS-1:0]   eff_lock;
    logic                    addr_ok;
    logic                    lock_hit;
    logic [CNT_W-1:0]        cnt_next;

    // Beat c of token a; callers guarantee a < NUM_TOKENS and c < BEATS.
    function automatic logic [BUS_WIDTH-1:0] beat_of(input logic [ADDR_W-1:0] a,
                                                     input logic [CNT_W-1:0]  c);
        logic [IDX_W-1:0] base;
        base = IDX_W'(32'(a) * TOKEN_WIDTH + 32'(c) * BUS_WIDTH);
        return TOKEN_INIT[base +: BUS_WIDTH];
    endfunction

    // Accept-time checks: range, and lock including a same-cycle lock request.
    always_comb begin
        eff_lock = locked_q | (lock_valid ? lock_mask : '0);
        addr_ok  = (32'(req_addr) < NUM_TOKENS);
        lock_hit = 1'b0;
        for (int i = 0; i < NUM_TOKENS; i++) begin
            if (req_addr == ADDR_W'(i) && eff_lock[i]) begin
                lock_hit = 1'b1;
            end
        end
    end

    // Next-state and registered-output computation for the response FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        last_d   = last_q;
        err_d    = err_q;
        valid_d  = valid_q;
        locked_d = lock_valid ? (locked_q | lock_mask) : locked_q;
        cnt_next = cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    valid_d = 1'b1;
                    if (!addr_ok || lock_hit) begin
                        state_d = ERR;
                        data_d  = '0;
                        last_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        state_d = STREAM;
                        cnt_d   = '0;
                        addr_d  = req_addr;
                        data_d  = beat_of(req_addr, '0);
                        last_d  = (BEATS == 1);
                        err_d   = 1'b0;
                    end
                end
            end
            STREAM: begin
                if (rd_ready) begin
                    if (last_q) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        cnt_d   = '0;
                        data_d  = '0;
                        last_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_next;
                        data_d = beat_of(addr_q, cnt_next);
                        last_d = (cnt_next == CNT_W'(BEATS - 1));
                    end
                end
            end
            ERR: begin
                if (rd_ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                data_d  = '0;
                last_d  = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State, lock and output registers; reset aborts any response at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            locked_q <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            last_q   <= last_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign locked    = locked_q;
    assign rd_valid  = valid_q;
    assign rd_data   = data_q;
    assign rd_last   = last_q;
    assign rd_err    = err_q;

endmodule
